// File: rtl/functdec_pkg.sv
// Shared types for the registered function decoder: ALU/byte-access/load-extension
// encodings and the decoded beat carried through the skid buffer.
package functdec_pkg;

    // Widest sideband the decoded struct can carry; narrower tags are zero-extended.
    localparam int TAG_W_MAX = 16;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SLT    = 5'b00101,
        ALU_SLTU   = 5'b00110,
        ALU_SLL    = 5'b00111,
        ALU_SRL    = 5'b01000,
        ALU_SRA    = 5'b01001,
        ALU_BEQ    = 5'b01010,
        ALU_BNE    = 5'b01011,
        ALU_BGE    = 5'b01100,
        ALU_BGEU   = 5'b01101,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        BACC_WORD  = 2'b00,
        BACC_BYTE  = 2'b01,
        BACC_HALF  = 2'b10,
        BACC_DWORD = 2'b11
    } byte_access_e;

    typedef enum logic [2:0] {
        BSRC_LBU = 3'b000,
        BSRC_LHU = 3'b001,
        BSRC_LB  = 3'b010,
        BSRC_LH  = 3'b011,
        BSRC_LW  = 3'b100,
        BSRC_LWU = 3'b101,
        BSRC_LD  = 3'b110
    } byte_src_e;

    typedef enum logic [1:0] {
        DEC_MEM    = 2'b00,
        DEC_BRANCH = 2'b01,
        DEC_PASS   = 2'b10,
        DEC_ALU    = 2'b11
    } decop_e;

    typedef struct packed {
        alu_ctrl_e              alu;
        byte_access_e           bacc;
        byte_src_e              bsrc;
        logic                   wordop;
        logic                   illegal;
        logic [TAG_W_MAX-1:0]   tag;
    } decoded_t;

endpackage

// File: rtl/functdec_core.sv
// Pure combinational function decode into decoded_t. Illegal encodings zero every
// field except illegal/tag. M-extension decode is enabled by FUNCTDEC_MEXT_EN.
module functdec_core
    import functdec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]           decop,
    input  logic                 op5,
    input  logic                 opw,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 funct7b0,
    input  logic [TAG_W_MAX-1:0] tag,
    output decoded_t             dec
);

    localparam bit IS64 = (XLEN == 64);

    always_comb begin
        dec     = '0;
        dec.tag = tag;
        case (decop_e'(decop))
            DEC_MEM: begin
                dec.alu = ALU_ADD;
                case (funct3)
                    3'b000:  begin dec.bacc = BACC_BYTE; dec.bsrc = BSRC_LB;  end
                    3'b001:  begin dec.bacc = BACC_HALF; dec.bsrc = BSRC_LH;  end
                    3'b010:  begin dec.bacc = BACC_WORD; dec.bsrc = BSRC_LW;  end
                    3'b100:  begin dec.bacc = BACC_BYTE; dec.bsrc = BSRC_LBU; end
                    3'b101:  begin dec.bacc = BACC_HALF; dec.bsrc = BSRC_LHU; end
                    3'b011:  begin
                        if (IS64) begin dec.bacc = BACC_DWORD; dec.bsrc = BSRC_LD; end
                        else dec.illegal = 1'b1;
                    end
                    3'b110:  begin
                        if (IS64) begin dec.bacc = BACC_WORD; dec.bsrc = BSRC_LWU; end
                        else dec.illegal = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            DEC_BRANCH: begin
                case (funct3)
                    3'b000:  dec.alu = ALU_BEQ;
                    3'b001:  dec.alu = ALU_BNE;
                    3'b100:  dec.alu = ALU_SLT;
                    3'b101:  dec.alu = ALU_BGE;
                    3'b110:  dec.alu = ALU_SLTU;
                    3'b111:  dec.alu = ALU_BGEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            DEC_PASS: dec.alu = ALU_ADD;
            default: begin
                if (op5 && funct7b0) begin
`ifdef FUNCTDEC_MEXT_EN
                    dec.alu = alu_ctrl_e'({2'b10, funct3});
                    // Only mulw/divw/divuw/remw/remuw exist in the W space.
                    if (opw && (!IS64 || funct3 inside {3'b001, 3'b010, 3'b011}))
                        dec.illegal = 1'b1;
                    else
                        dec.wordop = opw;
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    case (funct3)
                        3'b000:  dec.alu = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec.alu = ALU_SLL;
                        3'b010:  dec.alu = ALU_SLT;
                        3'b011:  dec.alu = ALU_SLTU;
                        3'b100:  dec.alu = ALU_XOR;
                        3'b101:  dec.alu = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  dec.alu = ALU_OR;
                        default: dec.alu = ALU_AND;
                    endcase
                    if (opw) begin
                        if (!IS64 || !(funct3 inside {3'b000, 3'b001, 3'b101}))
                            dec.illegal = 1'b1;
                        else
                            dec.wordop = 1'b1;
                    end
                end
            end
        endcase

        if (dec.illegal) begin
            dec.alu    = ALU_ADD;
            dec.bacc   = BACC_WORD;
            dec.bsrc   = BSRC_LBU;
            dec.wordop = 1'b0;
        end
    end

endmodule

// File: rtl/functdec_pipe.sv
// Registered, handshaked function decoder with a 2-entry skid buffer and flush.
// Define FUNCTDEC_MEXT_EN to decode M-extension operations.
module functdec_pipe
    import functdec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int ALUC_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        DecOp,
    input  logic              op5,
    input  logic              opW,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [1:0]        ByteAccess,
    output logic [2:0]        ByteSrc,
    output logic              WordOp,
    output logic              Illegal,
    output logic [TAG_W-1:0]  out_tag
);

    decoded_t dec;
    decoded_t main_reg, main_next;
    decoded_t skid_reg, skid_next;
    logic     main_valid_reg, main_valid_next;
    logic     skid_valid_reg, skid_valid_next;
    logic     accept, drain;
    logic     unused_tag_bits;

    functdec_core #(.XLEN(XLEN)) u_core (
        .decop    (DecOp),
        .op5      (op5),
        .opw      (opW),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .tag      (TAG_W_MAX'(in_tag)),
        .dec      (dec)
    );

    assign accept = in_valid && !skid_valid_reg && !flush;
    assign drain  = main_valid_reg && out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            if (drain) begin
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end
        end else if (main_valid_reg && !drain) begin
            // Output stalled: park the new beat in the skid entry.
            if (accept) begin
                skid_next       = dec;
                skid_valid_next = 1'b1;
            end
        end else begin
            main_valid_next = accept;
            if (accept) main_next = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign in_ready        = !skid_valid_reg;
    assign out_valid       = main_valid_reg;
    assign ALUControl      = ALUC_W'(main_reg.alu);
    assign ByteAccess      = main_reg.bacc;
    assign ByteSrc         = main_reg.bsrc;
    assign WordOp          = main_reg.wordop;
    assign Illegal         = main_reg.illegal;
    assign out_tag         = main_reg.tag[TAG_W-1:0];
    assign unused_tag_bits = ^main_reg.tag;

endmodule

// File: tb/tb_functdec_pipe.sv
// Scoreboard bench: an XLEN=64 and an XLEN=32 instance share all stimulus;
// expected decodes are queued at accept and popped by a monitor on output handshake.
module tb_functdec_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] DecOp = '0;
    logic       op5 = 1'b0, opW = 1'b0, funct7b5 = 1'b0, funct7b0 = 1'b0;
    logic [2:0] funct3 = '0;
    logic [4:0] in_tag = '0;

    logic       rdy64, vld64, w64, il64, rdy32, vld32, w32, il32;
    logic [4:0] alu64, tag64, alu32, tag32;
    logic [1:0] ba64, ba32;
    logic [2:0] bs64, bs32;

    always #5 clk = ~clk;

    functdec_pipe #(.XLEN(64), .TAG_W(5), .ALUC_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .DecOp(DecOp), .op5(op5), .opW(opW), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
        .ALUControl(alu64), .ByteAccess(ba64), .ByteSrc(bs64), .WordOp(w64),
        .Illegal(il64), .out_tag(tag64)
    );

    functdec_pipe #(.XLEN(32), .TAG_W(5), .ALUC_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .DecOp(DecOp), .op5(op5), .opW(opW), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
        .ALUControl(alu32), .ByteAccess(ba32), .ByteSrc(bs32), .WordOp(w32),
        .Illegal(il32), .out_tag(tag32)
    );

    typedef struct packed {
        logic [4:0] alu;
        logic [1:0] bacc;
        logic [2:0] bsrc;
        logic       w;
        logic       il;
    } exp_t;

    typedef struct packed {
        exp_t       e;
        logic [4:0] tag;
    } sb_t;

    typedef struct {
        logic [1:0] decop;
        logic       op5, opw;
        logic [2:0] f3;
        logic       f7b5, f7b0;
        exp_t       e64, e32;
    } vec_t;

    vec_t vecs[$];
    sb_t  q64[$], q32[$];
    int   checks = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic [4:0] alu, input logic [1:0] bacc,
                                input logic [2:0] bsrc, input logic w, input logic il);
        exp_t e;
        e.alu = alu; e.bacc = bacc; e.bsrc = bsrc; e.w = w; e.il = il;
        return e;
    endfunction

    task automatic add(input logic [1:0] d, input logic o5, input logic ow, input logic [2:0] f3,
                       input logic b5, input logic b0, input exp_t e64, input exp_t e32);
        vec_t v;
        v.decop = d; v.op5 = o5; v.opw = ow; v.f3 = f3; v.f7b5 = b5; v.f7b0 = b0;
        v.e64 = e64; v.e32 = e32;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic issue(input vec_t v, input logic [4:0] tag);
        int n = 0;
        DecOp = v.decop; op5 = v.op5; opW = v.opw; funct3 = v.f3;
        funct7b5 = v.f7b5; funct7b0 = v.f7b0; in_tag = tag; in_valid = 1'b1;
        while (!rdy64 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy64) begin
            checks++; failures++;
            $display("FAIL issue_wait tag=%0d actual=in_ready_low required=accept", tag);
        end else begin
            q64.push_back('{e: v.e64, tag: tag});
            q32.push_back('{e: v.e32, tag: tag});
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_left", q64.size() + q32.size(), 0);
    endtask

    // Monitor: pop and compare whenever a handshake will occur at the next edge.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && vld64 && out_ready) begin
                if (q64.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out64_unexpected actual=tag%0d required=none", tag64);
                end else begin
                    e = q64.pop_front();
                    chk($sformatf("out64_tag%0d", e.tag), {alu64, ba64, bs64, w64, il64, tag64}, e);
                end
            end
            if (rst_n && vld32 && out_ready) begin
                if (q32.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL out32_unexpected actual=tag%0d required=none", tag32);
                end else begin
                    e = q32.pop_front();
                    chk($sformatf("out32_tag%0d", e.tag), {alu32, ba32, bs32, w32, il32, tag32}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t ill;
        time  t0;
        ill = mk(5'd0, 2'd0, 3'd0, 1'b0, 1'b1);

        add(2'd3, 1, 0, 3'd0, 1, 0, mk(5'd1, 0, 0, 0, 0), mk(5'd1, 0, 0, 0, 0));   // sub
        add(2'd3, 0, 0, 3'd0, 1, 0, mk(5'd0, 0, 0, 0, 0), mk(5'd0, 0, 0, 0, 0));   // addi
        add(2'd0, 0, 0, 3'd6, 0, 0, mk(5'd0, 0, 3'd5, 0, 0), ill);                 // lwu
        add(2'd0, 0, 0, 3'd3, 0, 0, mk(5'd0, 2'd3, 3'd6, 0, 0), ill);              // ld
        add(2'd0, 0, 0, 3'd0, 0, 0, mk(5'd0, 2'd1, 3'd2, 0, 0), mk(5'd0, 2'd1, 3'd2, 0, 0)); // lb
        add(2'd0, 0, 0, 3'd5, 0, 0, mk(5'd0, 2'd2, 3'd1, 0, 0), mk(5'd0, 2'd2, 3'd1, 0, 0)); // lhu
        add(2'd0, 0, 0, 3'd2, 0, 0, mk(5'd0, 2'd0, 3'd4, 0, 0), mk(5'd0, 2'd0, 3'd4, 0, 0)); // lw
        add(2'd0, 0, 0, 3'd7, 0, 0, ill, ill);
        add(2'd1, 0, 0, 3'd5, 0, 0, mk(5'd12, 0, 0, 0, 0), mk(5'd12, 0, 0, 0, 0)); // bge
        add(2'd1, 0, 0, 3'd6, 0, 0, mk(5'd6, 0, 0, 0, 0), mk(5'd6, 0, 0, 0, 0));   // bltu
        add(2'd1, 0, 0, 3'd4, 0, 0, mk(5'd5, 0, 0, 0, 0), mk(5'd5, 0, 0, 0, 0));   // blt
        add(2'd1, 0, 0, 3'd2, 0, 0, ill, ill);
        add(2'd2, 1, 0, 3'd7, 1, 1, mk(5'd0, 0, 0, 0, 0), mk(5'd0, 0, 0, 0, 0));   // lui/jal
        add(2'd3, 0, 0, 3'd5, 1, 0, mk(5'd9, 0, 0, 0, 0), mk(5'd9, 0, 0, 0, 0));   // srai
        add(2'd3, 1, 0, 3'd5, 0, 0, mk(5'd8, 0, 0, 0, 0), mk(5'd8, 0, 0, 0, 0));   // srl
        add(2'd3, 1, 0, 3'd7, 0, 0, mk(5'd2, 0, 0, 0, 0), mk(5'd2, 0, 0, 0, 0));   // and
        add(2'd3, 1, 0, 3'd6, 0, 0, mk(5'd3, 0, 0, 0, 0), mk(5'd3, 0, 0, 0, 0));   // or
        add(2'd3, 0, 0, 3'd1, 0, 0, mk(5'd7, 0, 0, 0, 0), mk(5'd7, 0, 0, 0, 0));   // slli
        add(2'd3, 1, 0, 3'd3, 0, 0, mk(5'd6, 0, 0, 0, 0), mk(5'd6, 0, 0, 0, 0));   // sltu
        add(2'd3, 1, 0, 3'd4, 0, 0, mk(5'd4, 0, 0, 0, 0), mk(5'd4, 0, 0, 0, 0));   // xor
        add(2'd3, 0, 0, 3'd2, 0, 0, mk(5'd5, 0, 0, 0, 0), mk(5'd5, 0, 0, 0, 0));   // slti
        add(2'd3, 0, 0, 3'd0, 0, 1, mk(5'd0, 0, 0, 0, 0), mk(5'd0, 0, 0, 0, 0));   // addi, imm bit25
        add(2'd3, 1, 1, 3'd0, 0, 0, mk(5'd0, 0, 0, 1, 0), ill);                    // addw
        add(2'd3, 1, 1, 3'd0, 1, 0, mk(5'd1, 0, 0, 1, 0), ill);                    // subw
        add(2'd3, 1, 1, 3'd5, 1, 0, mk(5'd9, 0, 0, 1, 0), ill);                    // sraw
        add(2'd3, 1, 1, 3'd2, 0, 0, ill, ill);                                     // no sltw
`ifdef FUNCTDEC_MEXT_EN
        add(2'd3, 1, 0, 3'd4, 0, 1, mk(5'd20, 0, 0, 0, 0), mk(5'd20, 0, 0, 0, 0)); // div
        add(2'd3, 1, 0, 3'd0, 0, 1, mk(5'd16, 0, 0, 0, 0), mk(5'd16, 0, 0, 0, 0)); // mul
        add(2'd3, 1, 1, 3'd4, 0, 1, mk(5'd20, 0, 0, 1, 0), ill);                   // divw
        add(2'd3, 1, 1, 3'd1, 0, 1, ill, ill);                                     // no mulhw
`else
        add(2'd3, 1, 0, 3'd4, 0, 1, ill, ill);
        add(2'd3, 1, 0, 3'd0, 0, 1, ill, ill);
        add(2'd3, 1, 1, 3'd4, 0, 1, ill, ill);
        add(2'd3, 1, 1, 3'd1, 0, 1, ill, ill);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid64", vld64, 0);
        chk("rst_out_valid32", vld32, 0);
        chk("rst_in_ready64", rdy64, 1);
        chk("rst_data64", {alu64, ba64, bs64, w64, il64, tag64}, 0);
        chk("rst_data32", {alu32, ba32, bs32, w32, il32, tag32}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", rdy64, 1);

        // First beat: one-cycle latency
        issue(vecs[0], 5'd30);
        chk("latency_out_valid", vld64, 1);
        chk("latency_alu", alu64, 5'b00001);
        wait_drain();

        // Full-throughput stream of every vector
        t0 = $time;
        foreach (vecs[i]) issue(vecs[i], 5'(i + 1));
        chk("throughput_cycles", ($time - t0) / 10, vecs.size());
        wait_drain();

        // Stall: tags 1,2,3 back-to-back with out_ready low
        out_ready = 1'b0;
        issue(vecs[0], 5'd1);
        chk("one_held_in_ready", rdy64, 1);
        issue(vecs[1], 5'd2);
        chk("stall_in_ready", rdy64, 0);
        chk("stall_hold_tag", tag64, 5'd1);
        fork
            issue(vecs[2], 5'd3);
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("no_dup_out_valid", vld64, 0);

        // Flush with two entries held and a live input beat
        out_ready = 1'b0;
        issue(vecs[3], 5'd4);
        issue(vecs[4], 5'd5);
        chk("pre_flush_in_ready", rdy64, 0);
        DecOp = 2'd3; op5 = 1'b1; opW = 1'b0; funct3 = 3'd0; in_tag = 5'd9;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        q64.delete();
        q32.delete();
        chk("flush_out_valid", vld64, 0);
        chk("flush_in_ready", rdy64, 1);
        chk("flush_out_valid32", vld32, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_no_ghost", vld64, 0);
        issue(vecs[8], 5'd6);
        wait_drain();

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        issue(vecs[5], 5'd7);
        issue(vecs[6], 5'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid64", vld64, 0);
        chk("async_rst_out_valid32", vld32, 0);
        q64.delete();
        q32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", rdy64, 1);
        chk("rst_release_out_valid", vld64, 0);
        issue(vecs[13], 5'd11);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/functdec_pipe.md
Name: functdec_pipe

Overview:
- Registered, handshaked successor to the combinational function decoder in the 6-stage core; sits at the ID/EX boundary.
- Decodes {DecOp, op5, funct3, funct7b5, funct7b0, opW} into ALUControl, ByteAccess and ByteSrc.
- Adds RV64 support (ld/lwu/W-ops), illegal-encoding detection, a sideband tag, flush, and a 2-entry skid buffer so in_ready is a register output.

Parameters:
- XLEN, 32, datapath width; only 32 or 64 legal; 64 enables ld, lwu and W ops.
- TAG_W, 5, width of opaque sideband (e.g. rd) carried alongside each decode.
- ALUC_W, 5, ALUControl width; bit 4 is set only for M-extension codes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held entries and the current input.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept; registered.
- DecOp  in  2  00 load/store, 01 branch, 10 passthrough (lui/jal), 11 ALU.
- op5  in  1  1 = R-type, 0 = I-type.
- opW  in  1  1 = OP-32/OP-IMM-32 (W op).
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instr[30].
- funct7b0  in  1  instr[25] (M-extension select).
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- ALUControl  out  ALUC_W  ALU operation.
- ByteAccess  out  2  00 word, 01 byte, 10 half, 11 dword.
- ByteSrc  out  3  load extension: 000 lbu, 001 lhu, 010 lb, 011 lh, 100 lw, 101 lwu, 110 ld.
- WordOp  out  1  result is 32-bit, sign-extended (RV64 W ops).
- Illegal  out  1  encoding not supported.
- out_tag  out  TAG_W  sideband.

Behaviour:
- ALU codes:
  - add 00000, sub 00001, and 00010, or 00011, xor 00100, slt 00101, sltu 00110, sll 00111, srl 01000, sra 01001.
  - beq 01010, bne 01011, bge 01100, bgeu 01101; blt uses slt, bltu uses sltu.
- DecOp=00:
  - ALU = add.
  - funct3 000/001/010/100/101 map to byte/half/word with ByteSrc 010/011/100/000/001.
  - XLEN=64: 011 gives ByteAccess 11 / ByteSrc 110; 110 gives 00 / 101.
  - Any other funct3 sets Illegal.
- DecOp=01:
  - Branch codes above; ByteAccess 00, ByteSrc 000.
  - funct3 010/011 set Illegal.
- DecOp=10: ALU 00000, ByteAccess 00, ByteSrc 000.
- DecOp=11:
  - funct3 000: sub only if op5 & funct7b5.
  - funct3 101: sra if funct7b5, else srl.
  - Remaining funct3 values map in order 001 sll, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
- Non-load ByteSrc is always 000; outputs never carry X.
- opW:
  - XLEN=64: WordOp = opW for DecOp=11.
  - opW=1 with funct3 not in {000,001,101} sets Illegal.
  - XLEN=32: opW=1 sets Illegal and WordOp stays 0.
- Handshake:
  - Accept when in_valid & in_ready.
  - Latency is 1 cycle from accept to out_valid.
  - Output fields are held stable while out_valid & !out_ready.
- Skid buffer (main + skid entries):
  - in_ready = !skid_full.
  - Accept with output stalled: the beat goes to skid; in_ready falls next cycle.
  - Output drains: skid moves to main.
  - Sustained full throughput with out_ready=1.
  - Simultaneous accept and drain when 1 entry is held: occupancy stays 1.
- Flush:
  - Clears both entries at the next edge; out_valid=0, in_ready=1 next cycle.
  - An input beat presented in the flush cycle is dropped.
  - Flush has priority over accept.
- Reset: out_valid=0, in_ready=1 after release, all data outputs 0, occupancy 0. Async assertion mid-transfer drops all entries.

Optional Feature:
- FUNCTDEC_MEXT_EN defined, for DecOp=11, op5=1, funct7b0=1:
  - ALUControl = {2'b10, funct3}: mul 10000 … remu 10111.
  - With opW=1 (XLEN=64), only funct3 000/100/101/110/111 are legal.
- Undefined: the same encoding sets Illegal with ALU 00000; bit 4 is never set.

Decomposition:
- Package functdec_pkg holds:
  - alu_ctrl_e, byte_access_e, byte_src_e and decop_e enums.
  - decoded_t struct {alu, bacc, bsrc, wordop, illegal, tag}.
- Sub-module functdec_core is the pure combinational decode to decoded_t.
- functdec_pipe holds the skid buffer, handshake and flush.

Test Plan:
- Reset, then DecOp=11, op5=1, funct3=000, funct7b5=1, out_ready=1 -> next cycle out_valid=1, ALUControl=00001.
- XLEN=64, DecOp=00, funct3=110 -> ByteAccess=00, ByteSrc=101. Same input with XLEN=32 -> Illegal=1.
- out_ready=0, 3 back-to-back beats with tags 1,2,3 -> in_ready=0 after beat 2; release -> tags out 1,2 then 3, no loss or duplicates.
- Flush with 2 entries held and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
- With FUNCTDEC_MEXT_EN: DecOp=11, op5=1, funct7b0=1, funct3=100 -> ALUControl=10100. Without the macro -> Illegal=1, ALUControl=00000.
- rst_n asserted mid-stall -> out_valid=0 immediately; after release, in_ready=1.
